// File: rtl/morse_tx_sequencer.sv
// Converts ASCII characters into paced dot/dash/space pulses for trans_fsm.
// Optional digit support: define MORSE_DIGITS_EN to add 0-9 to the lookup.
module morse_tx_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       dot_inp,
  output logic       dash_inp,
  output logic       char_space_inp,
  output logic       word_space_inp,
  output logic       busy,
  output logic       char_err
);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, SYM, GAP, CSP, WSP, CWAIT, WWAIT, DROP
  } state_t;

  localparam logic [1:0] K_SYM = 2'd0;
  localparam logic [1:0] K_SPC = 2'd1;
  localparam logic [1:0] K_BAD = 2'd2;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [2:0] rem, rem_n;
  logic [4:0] sh, sh_n;
  logic [1:0] lk_kind;
  logic [2:0] lk_len;
  logic [4:0] lk_pat;
  logic       dot_n, dash_n, csp_n, wsp_n, err_n;

  // Returns {kind, len, pattern}; the pattern is left-aligned so the first
  // symbol always sits in bit 4 regardless of length.
  function automatic logic [9:0] lookup(input logic [7:0] c);
    logic [7:0] u;
    logic [9:0] r;
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    r = {K_BAD, 3'd0, 5'b00000};
    case (u)
      8'h20: r = {K_SPC, 3'd0, 5'b00000};
      "A": r = {K_SYM, 3'd2, 5'b01000};
      "B": r = {K_SYM, 3'd4, 5'b10000};
      "C": r = {K_SYM, 3'd4, 5'b10100};
      "D": r = {K_SYM, 3'd3, 5'b10000};
      "E": r = {K_SYM, 3'd1, 5'b00000};
      "F": r = {K_SYM, 3'd4, 5'b00100};
      "G": r = {K_SYM, 3'd3, 5'b11000};
      "H": r = {K_SYM, 3'd4, 5'b00000};
      "I": r = {K_SYM, 3'd2, 5'b00000};
      "J": r = {K_SYM, 3'd4, 5'b01110};
      "K": r = {K_SYM, 3'd3, 5'b10100};
      "L": r = {K_SYM, 3'd4, 5'b01000};
      "M": r = {K_SYM, 3'd2, 5'b11000};
      "N": r = {K_SYM, 3'd2, 5'b10000};
      "O": r = {K_SYM, 3'd3, 5'b11100};
      "P": r = {K_SYM, 3'd4, 5'b01100};
      "Q": r = {K_SYM, 3'd4, 5'b11010};
      "R": r = {K_SYM, 3'd3, 5'b01000};
      "S": r = {K_SYM, 3'd3, 5'b00000};
      "T": r = {K_SYM, 3'd1, 5'b10000};
      "U": r = {K_SYM, 3'd3, 5'b00100};
      "V": r = {K_SYM, 3'd4, 5'b00010};
      "W": r = {K_SYM, 3'd3, 5'b01100};
      "X": r = {K_SYM, 3'd4, 5'b10010};
      "Y": r = {K_SYM, 3'd4, 5'b10110};
      "Z": r = {K_SYM, 3'd4, 5'b11000};
`ifdef MORSE_DIGITS_EN
      "0": r = {K_SYM, 3'd5, 5'b11111};
      "1": r = {K_SYM, 3'd5, 5'b01111};
      "2": r = {K_SYM, 3'd5, 5'b00111};
      "3": r = {K_SYM, 3'd5, 5'b00011};
      "4": r = {K_SYM, 3'd5, 5'b00001};
      "5": r = {K_SYM, 3'd5, 5'b00000};
      "6": r = {K_SYM, 3'd5, 5'b10000};
      "7": r = {K_SYM, 3'd5, 5'b11000};
      "8": r = {K_SYM, 3'd5, 5'b11100};
      "9": r = {K_SYM, 3'd5, 5'b11110};
`else
`endif
      default: r = {K_BAD, 3'd0, 5'b00000};
    endcase
    return r;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    sh_n    = sh;
    dot_n   = 1'b0;
    dash_n  = 1'b0;
    csp_n   = 1'b0;
    wsp_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: if (char_valid && char_ready) state_n = LOOKUP;
      LOOKUP: begin
        if (lk_kind == K_SPC) begin
          state_n = WSP;
          wsp_n   = 1'b1;
        end else if (lk_kind == K_BAD) begin
          state_n = DROP;
          err_n   = 1'b1;
        end else begin
          state_n = SYM;
          dash_n  = lk_pat[4];
          dot_n   = ~lk_pat[4];
          sh_n    = {lk_pat[3:0], 1'b0};
          rem_n   = lk_len - 3'd1;
        end
      end
      SYM: begin
        state_n = GAP;
        cnt_n   = 3'd0;
      end
      GAP: begin
        if (cnt != 3'd0) begin
          cnt_n = cnt - 3'd1;
        end else if (rem != 3'd0) begin
          state_n = SYM;
          dash_n  = sh[4];
          dot_n   = ~sh[4];
          sh_n    = {sh[3:0], 1'b0};
          rem_n   = rem - 3'd1;
        end else begin
          state_n = CSP;
          csp_n   = 1'b1;
        end
      end
      CSP: begin
        state_n = CWAIT;
        cnt_n   = 3'd2;
      end
      WSP: begin
        state_n = WWAIT;
        cnt_n   = 3'd6;
      end
      CWAIT, WWAIT: begin
        if (cnt == 3'd0) state_n = IDLE;
        else             cnt_n   = cnt - 3'd1;
      end
      DROP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      rem            <= 3'd0;
      sh             <= 5'd0;
      lk_kind        <= K_BAD;
      lk_len         <= 3'd0;
      lk_pat         <= 5'd0;
      char_ready     <= 1'b0;
      busy           <= 1'b0;
      dot_inp        <= 1'b0;
      dash_inp       <= 1'b0;
      char_space_inp <= 1'b0;
      word_space_inp <= 1'b0;
      char_err       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      rem            <= rem_n;
      sh             <= sh_n;
      if (state == IDLE && char_valid && char_ready)
        {lk_kind, lk_len, lk_pat} <= lookup(char_data);
      char_ready     <= (state_n == IDLE);
      busy           <= (state_n != IDLE);
      dot_inp        <= dot_n;
      dash_inp       <= dash_n;
      char_space_inp <= csp_n;
      word_space_inp <= wsp_n;
      char_err       <= err_n;
    end
  end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Directed bench for morse_tx_sequencer: pulse timing, pacing and reset abort.
module tb_morse_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready, dot_inp, dash_inp, char_space_inp, word_space_inp;
  logic       busy, char_err;

  int checks = 0;
  int errors = 0;

  morse_tx_sequencer dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .dot_inp(dot_inp), .dash_inp(dash_inp),
    .char_space_inp(char_space_inp), .word_space_inp(word_space_inp),
    .busy(busy), .char_err(char_err)
  );

  always #5 clk = ~clk;

  // cap bits: {ready, busy, err, wsp, csp, dash, dot}
  logic [6:0] cap   [0:31];
  logic [4:0] exp_m [0:31];

  // Downstream occupancy: pulses must be at least 2/4/8 cycles apart.
  int cyc = 0, last_cyc = -100, need = 0, viol = 0, multi = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      last_cyc <= -100;
      need     <= 0;
    end else if (dot_inp | dash_inp | char_space_inp | word_space_inp) begin
      if (cyc - last_cyc < need) viol <= viol + 1;
      if (int'(dot_inp) + int'(dash_inp) + int'(char_space_inp) + int'(word_space_inp) > 1)
        multi <= multi + 1;
      last_cyc <= cyc;
      need <= word_space_inp ? 8 : char_space_inp ? 4 : 2;
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) exp_m[i] = 5'd0;
  endtask

  // Streams the characters of s with valid held, capturing n cycles from c0.
  task automatic stream(input string s, input int n);
    int idx;
    logic xf;
    for (int i = 0; i < 50 && !char_ready; i++) @(negedge clk);
    chk({"ready_before_", s}, int'(char_ready), 1);
    @(posedge clk); #1;
    idx = 0;
    char_valid = 1'b1;
    char_data  = s[idx];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cap[c] = {char_ready, busy, char_err, word_space_inp, char_space_inp, dash_inp, dot_inp};
      xf = char_valid && char_ready;
      @(posedge clk); #1;
      if (xf) begin
        idx++;
        if (idx < s.len()) char_data = s[idx];
        else begin
          char_valid = 1'b0;
          char_data  = "Z";
        end
      end
    end
  endtask

  task automatic check_pulses(input string tag, input int n);
    for (int c = 0; c < n; c++)
      chk($sformatf("%s_pulses_c%0d", tag, c), int'(cap[c][4:0]), int'(exp_m[c]));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({char_ready, busy, char_err, word_space_inp,
                               char_space_inp, dash_inp, dot_inp}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("ready_after_reset", int'(char_ready), 1);

    // 'E': dot c2, csp c4, ready c8
    clear_exp(); exp_m[2] = 5'b00001; exp_m[4] = 5'b00100;
    stream("E", 9);
    check_pulses("E", 9);
    chk("E_ready_c0", int'(cap[0][6]), 1);
    chk("E_busy_c1", int'(cap[1][5]), 1);
    chk("E_ready_c7", int'(cap[7][6]), 0);
    chk("E_ready_c8", int'(cap[8][6]), 1);

    // 'a' and 'A': dot c2, dash c4, csp c6, ready c10
    clear_exp(); exp_m[2] = 5'b00001; exp_m[4] = 5'b00010; exp_m[6] = 5'b00100;
    stream("a", 11);
    check_pulses("a", 11);
    chk("a_ready_c9", int'(cap[9][6]), 0);
    chk("a_ready_c10", int'(cap[10][6]), 1);
    stream("A", 11);
    check_pulses("A", 11);
    chk("A_ready_c10", int'(cap[10][6]), 1);

    // "T T" streamed
    clear_exp();
    exp_m[2] = 5'b00010; exp_m[4] = 5'b00100; exp_m[10] = 5'b01000;
    exp_m[20] = 5'b00010; exp_m[22] = 5'b00100;
    stream("T T", 27);
    check_pulses("TsT", 27);
    chk("TsT_ready_c8", int'(cap[8][6]), 1);
    chk("TsT_ready_c18", int'(cap[18][6]), 1);
    chk("TsT_ready_c26", int'(cap[26][6]), 1);

    // '#': dropped
    clear_exp(); exp_m[2] = 5'b10000;
    stream("#", 4);
    check_pulses("hash", 4);
    chk("hash_ready_c2", int'(cap[2][6]), 0);
    chk("hash_ready_c3", int'(cap[3][6]), 1);

    // '5'
    clear_exp();
`ifdef MORSE_DIGITS_EN
    for (int k = 0; k < 5; k++) exp_m[2 + 2 * k] = 5'b00001;
    exp_m[12] = 5'b00100;
    stream("5", 17);
    check_pulses("five", 17);
    chk("five_ready_c16", int'(cap[16][6]), 1);
`else
    exp_m[2] = 5'b10000;
    stream("5", 4);
    check_pulses("five", 4);
    chk("five_ready_c3", int'(cap[3][6]), 1);
`endif

    // 'Q' aborted by reset in c5
    clear_exp(); exp_m[2] = 5'b00010; exp_m[4] = 5'b00010;
    stream("Q", 5);
    check_pulses("Q", 5);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("Q_abort_outputs", int'({char_ready, busy, char_err, word_space_inp,
                                 char_space_inp, dash_inp, dot_inp}), 0);
    @(negedge clk);
    chk("Q_ready_after_rst", int'(char_ready), 1);

    clear_exp(); exp_m[2] = 5'b00001; exp_m[4] = 5'b00100;
    stream("E", 9);
    check_pulses("E2", 9);
    chk("E2_ready_c8", int'(cap[8][6]), 1);

    repeat (2) @(negedge clk);
    chk("pacing_violations", viol, 0);
    chk("multi_pulse_cycles", multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
